// File: rtl/ws2812_frame_ctrl_pkg.sv
// ws2812_pkg: shared definitions for the WS2812B frame controller.
//   - state_e      : controller FSM states (IDLE, FETCH, SEND, LATCH)
//   - LATCH_CYCLES_50MHZ : default latch gap, 52 us at 50 MHz
//   - pixel field positions and extract helpers for {green,red,blue} words
//   - idx_width()  : buffer index width for a given pixel count
package ws2812_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    LATCH = 2'd3
  } state_e;

  localparam int LATCH_CYCLES_50MHZ = 2600;

  // Pixel word layout: green [23:16], red [15:8], blue [7:0]
  localparam int GREEN_LSB = 16;
  localparam int RED_LSB   = 8;
  localparam int BLUE_LSB  = 0;

  function automatic logic [7:0] px_green(input logic [23:0] px);
    return px[GREEN_LSB +: 8];
  endfunction

  function automatic logic [7:0] px_red(input logic [23:0] px);
    return px[RED_LSB +: 8];
  endfunction

  function automatic logic [7:0] px_blue(input logic [23:0] px);
    return px[BLUE_LSB +: 8];
  endfunction

  // Index width that exactly covers n buffer entries (at least one bit)
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ws2812_frame_ctrl_if.sv
// ws2812_frame_ctrl_if: pixel stream from the frame controller to the bit
// serializer.
//   pix_red/green/blue : 8-bit colour channels
//   pix_valid          : channels hold a pixel
//   pix_ready          : serializer accepts the pixel this cycle
// master = frame controller, slave = serializer.
interface ws2812_frame_ctrl_if;
  logic [7:0] pix_red;
  logic [7:0] pix_green;
  logic [7:0] pix_blue;
  logic       pix_valid;
  logic       pix_ready;

  modport master (
    output pix_red, pix_green, pix_blue, pix_valid,
    input  pix_ready
  );

  modport slave (
    input  pix_red, pix_green, pix_blue, pix_valid,
    output pix_ready
  );
endinterface

// File: rtl/ws2812_frame_ctrl_pixel_ram.sv
// ws2812_pixel_ram: NUM_LEDS x 24 frame buffer, one write port and one
// registered read-first read port, single clock.
//   clk, reset        : clock, synchronous active-high reset (read register only)
//   wr_en/wr_addr/wr_data : write port; addresses >= NUM_LEDS are dropped
//   rd_en/rd_addr     : load the read register from rd_addr
//   rd_data           : read register; holds while rd_en is low
module ws2812_pixel_ram
  import ws2812_pkg::*;
#(
  parameter int NUM_LEDS = 16,
  parameter int ADDR_W   = 4,
  parameter int IDX_W    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [23:0]       wr_data,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd_addr,
  output logic [23:0]       rd_data
);

  localparam logic [ADDR_W:0] DEPTH = (ADDR_W + 1)'(NUM_LEDS);

  logic [23:0] mem [NUM_LEDS];
  logic        wr_ok;
  logic [23:0] rd_data_d;
  logic [23:0] rd_data_q;

  // Write qualification and read-register next value
  always_comb begin
    wr_ok = wr_en && ({1'b0, wr_addr} < DEPTH);
    if (rd_en) begin
      rd_data_d = mem[rd_addr];
    end else begin
      rd_data_d = rd_data_q;
    end
  end

  // Buffer storage; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_addr[IDX_W-1:0]] <= wr_data;
    end
  end

  // Read register: sampling mem with a non-blocking write gives read-first
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q <= 24'd0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/ws2812_frame_ctrl.sv
// ws2812_frame_ctrl: streams a buffered frame of NUM_LEDS pixels to the
// WS2812B serializer, then holds the latch gap and pulses frame_done.
//   CLOCK_50, reset : clock and synchronous active-high reset
//   wr_en/wr_addr/wr_data : host writes into the pixel buffer (any state)
//   start       : request one frame (ignored while busy)
//   busy        : high from accepted start until frame_done
//   frame_done  : one-cycle pulse at the end of the latch gap
//   pix         : pixel stream (ws2812_frame_ctrl_if.master)
// Optional macro WS2812_AUTO_REFRESH_EN: after the latch gap restart at
// pixel 0 instead of returning to IDLE; only reset stops refresh.
module ws2812_frame_ctrl
  import ws2812_pkg::*;
#(
  parameter int NUM_LEDS     = 16,
  parameter int ADDR_W       = 4,
  parameter int LATCH_CYCLES = LATCH_CYCLES_50MHZ,
  parameter int LATCH_W      = 12
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [23:0]         wr_data,
  input  logic                start,
  output logic                busy,
  output logic                frame_done,
  ws2812_frame_ctrl_if.master pix
);

  localparam int                IDX_W      = idx_width(NUM_LEDS);
  localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_LEDS - 1);
  localparam logic [LATCH_W-1:0] LATCH_LAST = LATCH_W'(LATCH_CYCLES - 1);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  index_q, index_d;
  logic [LATCH_W-1:0] latch_cnt_q, latch_cnt_d;
  logic               busy_q, busy_d;
  logic               frame_done_q, frame_done_d;
  logic               pix_valid_q, pix_valid_d;
  logic               rd_en;
  logic [23:0]        rd_data;

  // The buffer's read register doubles as the pix_* output register
  ws2812_pixel_ram #(
    .NUM_LEDS (NUM_LEDS),
    .ADDR_W   (ADDR_W),
    .IDX_W    (IDX_W)
  ) u_ram (
    .clk     (CLOCK_50),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (index_q[IDX_W-1:0]),
    .rd_data (rd_data)
  );

  // Next-state and output logic
  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    latch_cnt_d  = latch_cnt_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    pix_valid_d  = pix_valid_q;
    rd_en        = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          index_d = {ADDR_W{1'b0}};
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      FETCH: begin
        rd_en       = 1'b1;
        pix_valid_d = 1'b1;
        state_d     = SEND;
      end
      SEND: begin
        if (pix_valid_q && pix.pix_ready) begin
          pix_valid_d = 1'b0;
          if (index_q == LAST_IDX) begin
            state_d     = LATCH;
            latch_cnt_d = {LATCH_W{1'b0}};
          end else begin
            state_d = FETCH;
            index_d = index_q + ADDR_W'(1'b1);
          end
        end else begin
          state_d = SEND;
        end
      end
      LATCH: begin
        pix_valid_d = 1'b0;
        if (latch_cnt_q == LATCH_LAST) begin
          frame_done_d = 1'b1;
          latch_cnt_d  = {LATCH_W{1'b0}};
`ifdef WS2812_AUTO_REFRESH_EN
          state_d = FETCH;
          index_d = {ADDR_W{1'b0}};
`else
          state_d = IDLE;
          busy_d  = 1'b0;
`endif
        end else begin
          latch_cnt_d = latch_cnt_q + LATCH_W'(1'b1);
        end
      end
      default: begin
        state_d     = IDLE;
        busy_d      = 1'b0;
        pix_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q      <= IDLE;
      index_q      <= {ADDR_W{1'b0}};
      latch_cnt_q  <= {LATCH_W{1'b0}};
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      pix_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      latch_cnt_q  <= latch_cnt_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      pix_valid_q  <= pix_valid_d;
    end
  end

  assign busy          = busy_q;
  assign frame_done    = frame_done_q;
  assign pix.pix_valid = pix_valid_q;
  assign pix.pix_green = px_green(rd_data);
  assign pix.pix_red   = px_red(rd_data);
  assign pix.pix_blue  = px_blue(rd_data);

endmodule
